// File: rtl/mkio_manchester_tx.sv
// mkio_manchester_tx: serialises 16-bit words into MKIO Manchester-II words (3-bit sync, 16 data bits, odd parity)
// with a one-word holding buffer so trains of words can go out back to back.
module mkio_manchester_tx #(
  parameter int HALF_BIT  = 25,
  parameter int MAX_WORDS = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] tx_data,
  input  logic        tx_cd,
  input  logic        tx_ready,
  output logic        ack,
  output logic        busy,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_en,
  output logic        done,
  output logic        timeout
);
  localparam int CW  = $clog2(HALF_BIT);
  localparam int NW  = $clog2(MAX_WORDS + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
  localparam logic [1:0] PARITY = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] hb_clk_q, hb_clk_d;
  logic [5:0]    hb_idx_q, hb_idx_d;
  logic [15:0]   buf_q, buf_d, sh_q, sh_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          buf_cd_q, buf_cd_d, cd_q, cd_d, par_q, par_d, full_q, full_d;
  logic          ack_q, ack_d, done_q, done_d, timeout_q, timeout_d;
  logic          hb_end, word_end, at_max, accept, reload, load, hi;

  always_comb begin
    hb_end    = state_q != IDLE && hb_clk_q == CW'(HALF_BIT - 1);
    word_end  = hb_end && hb_idx_q == 6'd39;
    at_max    = cnt_q == NW'(MAX_WORDS);
    accept    = tx_ready && !full_q && !timeout_q;
    reload    = word_end && full_q && !at_max;
    load      = (state_q == IDLE && full_q) || reload;
    hb_clk_d  = (state_q == IDLE || hb_end) ? '0 : hb_clk_q + 1'b1;
    hb_idx_d  = (state_q == IDLE || word_end) ? '0 : hb_end ? hb_idx_q + 1'b1 : hb_idx_q;
    sh_d      = load ? buf_q : (hb_end && state_q == DATA && hb_idx_q[0]) ? {sh_q[14:0], 1'b0} : sh_q;
    cd_d      = load ? buf_cd_q : cd_q;
    par_d     = load ? ~^buf_q : par_q;
    cnt_d     = load ? (reload ? cnt_q + 1'b1 : NW'(1)) : cnt_q;
    state_d   = load ? SYNC :
                word_end ? IDLE :
                (hb_end && hb_idx_q == 6'd5) ? DATA :
                (hb_end && hb_idx_q == 6'd37) ? PARITY : state_q;
    // a train that hits MAX_WORDS drops whatever is still buffered
    full_d    = (word_end && at_max) || load ? 1'b0 : accept ? 1'b1 : full_q;
    buf_d     = accept ? tx_data : buf_q;
    buf_cd_d  = accept ? tx_cd : buf_cd_q;
    ack_d     = accept;
    done_d    = word_end && !reload;
    timeout_d = timeout_q || (word_end && at_max);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hb_clk_q  <= '0;
      hb_idx_q  <= '0;
      buf_q     <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      buf_cd_q  <= 1'b0;
      cd_q      <= 1'b0;
      par_q     <= 1'b0;
      full_q    <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hb_clk_q  <= hb_clk_d;
      hb_idx_q  <= hb_idx_d;
      buf_q     <= buf_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      buf_cd_q  <= buf_cd_d;
      cd_q      <= cd_d;
      par_q     <= par_d;
      full_q    <= full_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // hi = positive half-bit; odd half-bits of data and parity are the complement
  always_comb begin
    hi = state_q == SYNC ? (hb_idx_q < 6'd3) ^ cd_q :
         state_q == DATA ? sh_q[15] ^ hb_idx_q[0] : par_q ^ hb_idx_q[0];
  end

  assign tx_en   = state_q != IDLE;
  assign tx_p    = tx_en & hi;
  assign tx_n    = tx_en & ~hi;
  assign busy    = full_q | tx_en;
  assign ack     = ack_q;
  assign done    = done_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_mkio_manchester_tx.sv
// tb_mkio_manchester_tx: random and directed word trains checked against a half-bit line model;
// a second instance with MAX_WORDS = 3 exercises the train-length timeout.
module tb_mkio_manchester_tx;
  logic clk, reset, tx_cd, tx_ready, sel, chk_on, mon_on, mon_busy, prev_en;
  logic [15:0] tx_data;
  logic a1, b1, p1, n1, e1, d1, t1, a2, b2, p2, n2, e2, d2, t2;
  logic m_ack, m_busy, m_p, m_n, m_en, m_done, m_to;
  logic [16:0] exp_q[$];
  logic [15:0] wd[0:7];
  logic        wc[0:7];
  int n_vec, n_bad, run, last_run, done_cnt;

  mkio_manchester_tx #(.HALF_BIT(2)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_cd(tx_cd), .tx_ready(tx_ready),
    .ack(a1), .busy(b1), .tx_p(p1), .tx_n(n1), .tx_en(e1), .done(d1), .timeout(t1));

  mkio_manchester_tx #(.HALF_BIT(2), .MAX_WORDS(3)) dut_to (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_cd(tx_cd), .tx_ready(tx_ready),
    .ack(a2), .busy(b2), .tx_p(p2), .tx_n(n2), .tx_en(e2), .done(d2), .timeout(t2));

  assign {m_ack, m_busy, m_p, m_n, m_en, m_done, m_to} =
    sel ? {a2, b2, p2, n2, e2, d2, t2} : {a1, b1, p1, n1, e1, d1, t1};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // expected line for one word: bit (39-k) is the level of half-bit k
  function automatic logic [39:0] line(input logic cd, input logic [15:0] d);
    logic [39:0] e;
    e[39:34] = cd ? 6'b000111 : 6'b111000;
    for (int i = 0; i < 16; i++) e[33-2*i -: 2] = d[15-i] ? 2'b10 : 2'b01;
    e[1:0] = (^d) ? 2'b01 : 2'b10;
    return e;
  endfunction

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      chk("excl_a", {31'd0, p1 & n1}, 0);
      chk("excl_b", {31'd0, p2 & n2}, 0);
      if (!e1) chk("idle_line_a", {30'd0, p1, n1}, 0);
      if (!e2) chk("idle_line_b", {30'd0, p2, n2}, 0);
      chk("done_edge", {31'd0, m_done}, {31'd0, prev_en & ~m_en & ~reset});
      if (m_en) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (m_done) done_cnt++;
      prev_en = m_en;
    end
  end

  initial begin
    logic [16:0] w;
    logic [39:0] e;
    mon_busy = 0;
    forever begin
      @(negedge clk);
      if (mon_on && m_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {31'd0, m_en}, 0);
          for (int i = 0; i < 80 && m_en; i++) @(negedge clk);
        end else begin
          mon_busy = 1;
          w = exp_q.pop_front();
          e = line(w[16], w[15:0]);
          for (int k = 0; k < 80; k++) begin
            if (k != 0) @(negedge clk);
            chk("line", {29'd0, m_en, m_p, m_n}, {29'd0, 1'b1, e[39-k/2], ~e[39-k/2]});
          end
          mon_busy = 0;
        end
      end
    end
  end

  task automatic present(input int n);
    logic got;
    tx_ready = 1;
    for (int i = 0; i < n; i++) begin
      tx_data = wd[i];
      tx_cd = wc[i];
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        got = m_ack;
      end
      chk("ack_seen", {31'd0, got}, 1);
      if (got) exp_q.push_back({wc[i], wd[i]});
      if (i == n - 1) tx_ready = 0;
      @(negedge clk);
      chk("ack_len", {31'd0, m_ack}, 0);
      chk("busy_on", {31'd0, m_busy}, 1);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 400 && (m_busy || mon_busy || exp_q.size() != 0); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, m_busy}, 0);
    chk("idle_queue", exp_q.size(), 0);
  endtask

  task automatic train(input int n);
    int d0;
    d0 = done_cnt;
    present(n);
    wait_idle();
    chk("train_run", last_run, 80 * n);
    chk("train_done", done_cnt - d0, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int acks, d0;
    logic got;
    n_vec = 0; n_bad = 0; run = 0; last_run = 0; done_cnt = 0; prev_en = 0;
    sel = 0; chk_on = 0; mon_on = 1;
    tx_ready = 0; tx_data = 0; tx_cd = 0;
    do_reset();
    chk("rst_a", {25'd0, a1, b1, p1, n1, e1, d1, t1}, 0);
    chk("rst_b", {25'd0, a2, b2, p2, n2, e2, d2, t2}, 0);
    chk_on = 1;

    wd[0] = 16'h0800; wc[0] = 0; train(1);
    wd[0] = 16'hFFFF; wc[0] = 1; train(1);
    wd[0] = 16'h0001; wc[0] = 1; train(1);
    wd[0] = 16'h0800; wc[0] = 0;
    wd[1] = 16'hA5A5; wc[1] = 1;
    wd[2] = 16'h5A5A; wc[2] = 1;
    wd[3] = 16'h0000; wc[3] = 1;
    train(4);

    for (int t = 0; t < 10; t++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        wd[i] = 16'($urandom);
        wc[i] = 1'($urandom);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      train(n);
    end

    mon_on = 0;
    tx_data = 16'($urandom); tx_cd = 0; tx_ready = 1;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = m_ack;
    end
    tx_ready = 0;
    chk("mid_ack", {31'd0, got}, 1);
    for (int c = 0; c < 10 && !m_en; c++) @(negedge clk);
    repeat (40) @(negedge clk);
    chk("mid_hb20_en", {31'd0, m_en}, 1);
    d0 = done_cnt;
    reset = 1;
    @(negedge clk);
    chk("mid_rst_line", {28'd0, m_en, m_p, m_n, m_busy}, 0);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("mid_rst_nodone", done_cnt - d0, 0);
    mon_on = 1;
    wd[0] = 16'($urandom); wc[0] = 1;
    train(1);

    sel = 1;
    do_reset();
    d0 = done_cnt;
    acks = 0;
    tx_data = 16'($urandom); tx_cd = 0; tx_ready = 1;
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      if (m_ack) begin
        acks++;
        if (acks <= 3) exp_q.push_back({tx_cd, tx_data});
        tx_data = 16'($urandom);
        tx_cd = 1'($urandom);
      end
    end
    chk("to_acks", acks, 4);
    chk("to_flag", {31'd0, m_to}, 1);
    chk("to_done", done_cnt - d0, 1);
    chk("to_run", last_run, 240);
    chk("to_queue", exp_q.size(), 0);
    chk("to_busy", {31'd0, m_busy}, 0);
    tx_ready = 0;
    do_reset();
    chk("to_cleared", {31'd0, m_to}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
